// File: rtl/mult16_serial_product_collector_if.sv
// Handshake bundle between the serial multiplier core, the product collector
// and the downstream consumer of parallel product words.
interface mult16_serial_product_collector_if #(
  parameter int PROD_W = 32,
  parameter int CNT_W  = 8
);
  logic              ser_bit;
  logic              ser_valid;
  logic              ser_first;
  logic [PROD_W-1:0] prod_data;
  logic              prod_valid;
  logic              prod_ready;
  logic              frame_err;
  logic              overflow;
  logic [CNT_W-1:0]  drop_cnt;
  logic              clr_err;

  // Source of serial bits / consumer of words.
  modport master (
    output ser_bit, ser_valid, ser_first, prod_ready, clr_err,
    input  prod_data, prod_valid, frame_err, overflow, drop_cnt
  );

  // The collector itself.
  modport slave (
    input  ser_bit, ser_valid, ser_first, prod_ready, clr_err,
    output prod_data, prod_valid, frame_err, overflow, drop_cnt
  );
endinterface

// File: rtl/mult16_serial_product_collector.sv
// Collects an LSB-first serial product stream into PROD_W-bit words, queues
// completed words in a small FIFO and presents them on a valid/ready output.
// Framing faults and dropped words are reported through sticky flags.
module mult16_serial_product_collector #(
  parameter int PROD_W     = 32,
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  mult16_serial_product_collector_if.slave     bus
);

  localparam int BIT_W = (PROD_W > 2) ? $clog2(PROD_W) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(PROD_W - 1);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(FIFO_DEPTH);

  // Capture state: cnt_q is the index of the next bit, 0 means idle.
  logic [BIT_W-1:0]  cnt_q, cnt_d;
  logic [PROD_W-1:0] sr_q, sr_d;

  // FIFO storage and bookkeeping.
  logic [PROD_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]  occ_q, occ_d, occ_left;

  // Registered outputs.
  logic [PROD_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              ferr_q, ferr_d;
  logic              ovf_q, ovf_d;
  logic [CNT_W-1:0]  drop_q, drop_d, drop_base;

  logic              push, pop, full, accept, drop, frame_evt;
  logic [PROD_W-1:0] push_word;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // The final bit bypasses the shift register straight into the pushed word.
  assign push_word = {bus.ser_bit, sr_q[PROD_W-2:0]};

  // Serial capture: frame start, bit accumulation, completion and framing faults.
  always_comb begin
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    push      = 1'b0;
    frame_evt = 1'b0;
    if (bus.ser_valid) begin
      if (bus.ser_first) begin
        // A restart abandons whatever partial frame was in progress.
        sr_d[0]   = bus.ser_bit;
        cnt_d     = BIT_W'(1);
        frame_evt = (cnt_q != '0);
      end else if (cnt_q == '0) begin
        frame_evt = 1'b1;
      end else if (cnt_q == LAST_BIT) begin
        push  = 1'b1;
        cnt_d = '0;
      end else begin
        sr_d[cnt_q] = bus.ser_bit;
        cnt_d       = cnt_q + 1'b1;
      end
    end
  end

  // FIFO next state; the head register is computed from the post-edge contents.
  always_comb begin
    pop      = valid_q & bus.prod_ready;
    full     = (occ_q == DEPTH_OCC);
    accept   = push & (~full | pop);
    drop     = push & full & ~pop;
    wr_ptr_d = accept ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    occ_left = pop ? occ_q - 1'b1 : occ_q;
    occ_d    = accept ? occ_left + 1'b1 : occ_left;
    valid_d  = (occ_d != '0);
    data_d   = '0;
    if (occ_left != '0) begin
      data_d = mem_q[rd_ptr_d];
    end else if (accept) begin
      data_d = push_word;
    end
  end

  // Sticky flags and saturating drop counter; a new event beats a clear.
  always_comb begin
    ferr_d    = (bus.clr_err ? 1'b0 : ferr_q) | frame_evt;
    ovf_d     = (bus.clr_err ? 1'b0 : ovf_q) | drop;
    drop_base = bus.clr_err ? '0 : drop_q;
    drop_d    = (drop && (drop_base != '1)) ? drop_base + 1'b1 : drop_base;
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      sr_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      cnt_q    <= cnt_d;
      sr_q     <= sr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ferr_q   <= ferr_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
    end
  end

  // Word storage; validity is tracked by the pointers, so no reset is needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[wr_ptr_q] <= push_word;
    end
  end

  assign bus.prod_data  = data_q;
  assign bus.prod_valid = valid_q;
  assign bus.frame_err  = ferr_q;
  assign bus.overflow   = ovf_q;
  assign bus.drop_cnt   = drop_q;

endmodule

// File: tb/tb_mult16_serial_product_collector.sv
// Directed bench for the serial product collector: framing, gaps, FIFO
// back-pressure, overflow, framing errors, async reset and saturation.
module tb_mult16_serial_product_collector;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  mult16_serial_product_collector_if #(.PROD_W(32), .CNT_W(8)) bus ();

  mult16_serial_product_collector #(
    .PROD_W(32), .FIFO_DEPTH(2), .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; the next rising edge consumes them.
  task automatic drive(input logic v, input logic b, input logic f);
    @(negedge clk);
    bus.ser_valid = v;
    bus.ser_bit   = b;
    bus.ser_first = f;
  endtask

  task automatic send_bits(input logic [31:0] w, input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, w[i], (i == 0));
      if (gaps && (i != n - 1)) drive(1'b0, 1'b0, 1'b0);
    end
  endtask

  logic [31:0] wr;

  initial begin
    rst = 1'b1;
    bus.ser_valid = 1'b0; bus.ser_bit = 1'b0; bus.ser_first = 1'b0;
    bus.prod_ready = 1'b1; bus.clr_err = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", bus.prod_valid, 0);
    check("rst_data", bus.prod_data, 0);
    check("rst_ferr", bus.frame_err, 0);
    check("rst_ovf", bus.overflow, 0);
    check("rst_drop", bus.drop_cnt, 0);
    rst = 1'b0;

    // 1: single frame, consumer ready
    send_bits(32'h0000_0C35, 32, 0);
    check("t1_pre_valid", bus.prod_valid, 0);
    drive(0, 0, 0);
    check("t1_valid", bus.prod_valid, 1);
    check("t1_data", bus.prod_data, 32'h0000_0C35);
    drive(0, 0, 0);
    check("t1_valid_drop", bus.prod_valid, 0);
    check("t1_data_empty", bus.prod_data, 0);

    // 2: same frame with gaps
    send_bits(32'h0000_0C35, 32, 1);
    drive(0, 0, 0);
    check("t2_valid", bus.prod_valid, 1);
    check("t2_data", bus.prod_data, 32'h0000_0C35);
    check("t2_ferr", bus.frame_err, 0);
    drive(0, 0, 0);

    // 3: back-pressure, third frame dropped
    bus.prod_ready = 1'b0;
    send_bits(32'hA5A5_0001, 32, 0);
    send_bits(32'h0000_B00B, 32, 0);
    send_bits(32'hCCCC_3333, 32, 0);
    drive(0, 0, 0);
    check("t3_ovf", bus.overflow, 1);
    check("t3_drop", bus.drop_cnt, 1);
    check("t3_head_a", bus.prod_data, 32'hA5A5_0001);
    repeat (3) drive(0, 0, 0);
    check("t3_hold_a", bus.prod_data, 32'hA5A5_0001);
    check("t3_hold_valid", bus.prod_valid, 1);
    bus.prod_ready = 1'b1;
    drive(0, 0, 0);
    check("t3_head_b", bus.prod_data, 32'h0000_B00B);
    check("t3_valid_b", bus.prod_valid, 1);
    drive(0, 0, 0);
    check("t3_empty", bus.prod_valid, 0);
    bus.clr_err = 1'b1;
    drive(0, 0, 0);
    bus.clr_err = 1'b0;
    check("t3_clr_ovf", bus.overflow, 0);
    check("t3_clr_drop", bus.drop_cnt, 0);

    // 4: restart mid-frame, stray bit, clear
    send_bits(32'hFFFF_FFFF, 10, 0);
    send_bits(32'hDEAD_BEEF, 32, 0);
    drive(0, 0, 0);
    check("t4_ferr", bus.frame_err, 1);
    check("t4_data", bus.prod_data, 32'hDEAD_BEEF);
    check("t4_valid", bus.prod_valid, 1);
    bus.clr_err = 1'b1;
    drive(0, 0, 0);
    bus.clr_err = 1'b0;
    check("t4_clr", bus.frame_err, 0);
    drive(1, 1, 0);
    drive(0, 0, 0);
    check("t4_stray_ferr", bus.frame_err, 1);
    check("t4_stray_novalid", bus.prod_valid, 0);
    bus.clr_err = 1'b1;
    drive(0, 0, 0);
    bus.clr_err = 1'b0;
    check("t4_clr2", bus.frame_err, 0);

    // 5: async reset in the middle of a frame
    bus.prod_ready = 1'b0;
    send_bits(32'h1234_5678, 32, 0);
    drive(1, 1, 0);
    send_bits(32'hFFFF_FFFF, 20, 0);
    drive(0, 0, 0);
    check("t5_pre_valid", bus.prod_valid, 1);
    check("t5_pre_ferr", bus.frame_err, 1);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_valid", bus.prod_valid, 0);
    check("t5_rst_data", bus.prod_data, 0);
    check("t5_rst_ferr", bus.frame_err, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.prod_ready = 1'b1;
    send_bits(32'h0000_0001, 32, 0);
    drive(0, 0, 0);
    check("t5_data", bus.prod_data, 32'h0000_0001);
    check("t5_ferr", bus.frame_err, 0);
    drive(0, 0, 0);

    // 6: core product -3 * 1234
    send_bits(32'hFFFF_F18A, 32, 0);
    drive(0, 0, 0);
    check("t6_prod", bus.prod_data, 32'hFFFF_F18A);
    drive(0, 0, 0);

    // 6b: full FIFO, pop and push on the same edge
    bus.prod_ready = 1'b0;
    send_bits(32'h1111_0000, 32, 0);
    send_bits(32'h2222_0000, 32, 0);
    wr = 32'h3333_0000;
    send_bits(wr, 31, 0);
    drive(1, wr[31], 0);
    bus.prod_ready = 1'b1;
    drive(0, 0, 0);
    check("t6_pp_drop", bus.drop_cnt, 0);
    check("t6_pp_ovf", bus.overflow, 0);
    check("t6_pp_head", bus.prod_data, 32'h2222_0000);
    drive(0, 0, 0);
    check("t6_pp_last", bus.prod_data, 32'h3333_0000);
    drive(0, 0, 0);
    check("t6_pp_empty", bus.prod_valid, 0);

    // 6c: drop counter saturation
    bus.prod_ready = 1'b0;
    send_bits(32'h5555_AAAA, 32, 0);
    send_bits(32'h6666_BBBB, 32, 0);
    for (int k = 0; k < 255; k++) send_bits(32'h0F0F_0F0F, 32, 0);
    drive(0, 0, 0);
    check("t6_sat255", bus.drop_cnt, 255);
    send_bits(32'h0F0F_0F0F, 32, 0);
    drive(0, 0, 0);
    check("t6_sat_hold", bus.drop_cnt, 255);
    check("t6_sat_ovf", bus.overflow, 1);
    check("t6_sat_head", bus.prod_data, 32'h5555_AAAA);
    wr = 32'h0F0F_0F0F;
    send_bits(wr, 31, 0);
    drive(1, wr[31], 0);
    bus.clr_err = 1'b1;
    drive(0, 0, 0);
    bus.clr_err = 1'b0;
    check("t6_clr_vs_drop_cnt", bus.drop_cnt, 1);
    check("t6_clr_vs_drop_ovf", bus.overflow, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
